// File: rtl/winograd_output_transform_6x6.sv
// Winograd F(4x4,3x3) output transform Y = A^T * M * A: column pass into T, then row pass into y.
// Optional macro WINOGRAD_OUT_SAT_EN: saturate results to OUT_W and flag clamping on ovf.
module winograd_output_transform_6x6 #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic signed [5:0][5:0][IN_W-1:0]     m,
    output logic signed [3:0][3:0][OUT_W-1:0]    y,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 ovf
);

    localparam int TW = IN_W + 5;
    localparam int FW = IN_W + 10;

    typedef enum logic [1:0] {StIdle, StColp, StRowp, StDone} state_e;

    state_e                          state_q, state_d;
    logic [2:0]                      cnt_q, cnt_d;
    logic [5:0][5:0][IN_W-1:0]       m_q, m_d;
    logic [3:0][5:0][TW-1:0]         t_q, t_d;
    logic [3:0][3:0][OUT_W-1:0]      y_q, y_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            ovf_q, ovf_d;

    logic [5:0][FW-1:0]              xin;
    logic [3:0][FW-1:0]              xo;
    logic [3:0][OUT_W-1:0]           rr;
    logic [3:0]                      clamp;

    // Apply A^T to a 6-vector with shifts and adds; both passes share this datapath.
    function automatic logic [3:0][FW-1:0] xform(input logic [5:0][FW-1:0] v);
        logic [3:0][FW-1:0] o;
        o[0] = v[0] + v[1] + v[2] + v[3] + v[4];
        o[1] = v[1] - v[2] + (v[3] << 1) - (v[4] << 1);
        o[2] = v[1] + v[2] + (v[3] << 2) + (v[4] << 2);
        o[3] = v[1] - v[2] + (v[3] << 3) - (v[4] << 3) + v[5];
        return o;
    endfunction

    always_comb begin
        for (int l = 0; l < 6; l++) begin
            if (state_q == StRowp) begin
                xin[l] = FW'($signed(t_q[cnt_q[1:0]][l]));
            end else begin
                xin[l] = FW'($signed(m_q[l][cnt_q]));
            end
        end
        xo = xform(xin);
    end

    if (OUT_W >= FW) begin : g_wide
        always_comb begin
            clamp = '0;
            for (int k = 0; k < 4; k++) begin
                rr[k] = OUT_W'($signed(xo[k]));
            end
        end
    end else begin : g_narrow
`ifdef WINOGRAD_OUT_SAT_EN
        always_comb begin
            rr    = '0;
            clamp = '0;
            for (int k = 0; k < 4; k++) begin
                // In range iff all bits above the OUT_W sign bit equal it.
                if ((&xo[k][FW-1:OUT_W-1]) || !(|xo[k][FW-1:OUT_W-1])) begin
                    rr[k] = xo[k][OUT_W-1:0];
                end else begin
                    clamp[k] = 1'b1;
                    rr[k]    = xo[k][FW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end
`else
        logic unused_hi;
        assign unused_hi = ^xo;
        always_comb begin
            clamp = '0;
            for (int k = 0; k < 4; k++) begin
                rr[k] = xo[k][OUT_W-1:0];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        t_d     = t_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = m;
                    ovf_d   = 1'b0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = StColp;
                end
            end
            StColp: begin
                for (int r = 0; r < 4; r++) begin
                    t_d[r][cnt_q] = TW'(xo[r]);
                end
                if (cnt_q == 3'd5) begin
                    cnt_d   = 3'd0;
                    state_d = StRowp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StRowp: begin
                y_d[cnt_q[1:0]] = rr;
                ovf_d           = ovf_q | (|clamp);
                if (cnt_q == 3'd3) begin
                    cnt_d   = 3'd0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            m_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            t_q     <= t_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_winograd_output_transform_6x6.sv
// Scoreboard bench for winograd_output_transform_6x6 with directed tiles and hand-derived results.
module tb_winograd_output_transform_6x6;

    typedef logic [5:0][5:0][31:0] mtile_t;
    typedef logic [3:0][3:0][31:0] ytile_t;
    typedef struct {
        ytile_t y;
        logic   ovf;
        int     cyc;
    } exp_t;

`ifdef WINOGRAD_OUT_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    // Column j of A^T: the output pattern produced by an impulse at index j.
    localparam int ACOL [6][4] = '{'{1, 0, 0, 0}, '{1, 1, 1, 1}, '{1, -1, 1, -1},
                                   '{1, 2, 4, 8}, '{1, -2, 4, -8}, '{0, 0, 0, 1}};
    localparam int RSUM [4] = '{5, 0, 10, 1};

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    mtile_t m;
    ytile_t y;
    logic   busy, done, ovf;
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    exp_t   sb[$];

    winograd_output_transform_6x6 #(.IN_W(32), .OUT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mtile_t fill(input int v);
        mtile_t t;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) t[r][c] = 32'(v);
        return t;
    endfunction

    function automatic mtile_t junk();
        mtile_t t;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) t[r][c] = $urandom;
        return t;
    endfunction

    function automatic mtile_t imp_m(input int r, input int c, input int v);
        mtile_t t = '0;
        t[r][c] = 32'(v);
        return t;
    endfunction

    function automatic ytile_t imp_y(input int r, input int c, input int v);
        ytile_t t;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) t[i][k] = 32'(ACOL[r][i] * v * ACOL[c][k]);
        return t;
    endfunction

    // Uniform tile of value s: every T row is constant RSUM[i]*s, so y[i][k] = RSUM[i]*RSUM[k]*s.
    function automatic ytile_t outer(input longint s, output logic ov);
        ytile_t t;
        longint p;
        ov = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                p = longint'(RSUM[i] * RSUM[k]) * s;
                if (Sat && p > 64'sd2147483647) begin
                    t[i][k] = 32'h7fff_ffff;
                    ov = 1'b1;
                end else if (Sat && p < -64'sd2147483648) begin
                    t[i][k] = 32'h8000_0000;
                    ov = 1'b1;
                end else begin
                    t[i][k] = p[31:0];
                end
            end
        return t;
    endfunction

    task automatic run_tile(input mtile_t mt, input ytile_t ey, input logic eovf, input bit pulses);
        exp_t e;
        @(negedge clk);
        m     = mt;
        start = 1'b1;
        e.y   = ey;
        e.ovf = eovf;
        e.cyc = cyc + 11;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        m     = junk();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("busy@%0d", k), 64'(busy), 64'(k <= 11));
            start = pulses && (k == 3 || k == 11);
            if (start) m = junk();
        end
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    for (int i = 0; i < 4; i++)
                        for (int k = 0; k < 4; k++)
                            chk($sformatf("y[%0d][%0d]", i, k), 64'(y[i][k]), 64'(e.y[i][k]));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                    chk("busy_at_done", 64'(busy), 64'd1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ytile_t ey;
        logic   eo;
        rst   = 1'b1;
        start = 1'b1;
        m     = fill(1);
        repeat (3) @(negedge clk);
        chk("reset_y", 64'(|y), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        rst   = 1'b0;
        start = 1'b0;

        run_tile(fill(0), '0, 1'b0, 1'b0);
        run_tile(imp_m(0, 0, 1), imp_y(0, 0, 1), 1'b0, 1'b0);
        run_tile(imp_m(5, 5, 1), imp_y(5, 5, 1), 1'b0, 1'b0);
        run_tile(imp_m(3, 3, 1), imp_y(3, 3, 1), 1'b0, 1'b0);
        run_tile(imp_m(4, 2, -1), imp_y(4, 2, -1), 1'b0, 1'b0);
        run_tile(imp_m(1, 4, 7), imp_y(1, 4, 7), 1'b0, 1'b0);

        ey = outer(64'sd1, eo);
        run_tile(fill(1), ey, eo, 1'b0);
        ey = outer(64'sd134217728, eo);
        run_tile(fill(32'sh0800_0000), ey, eo, 1'b0);
        ey = outer(-64'sd134217728, eo);
        run_tile(fill(-32'sh0800_0000), ey, eo, 1'b0);
        // ovf must clear on the next accepted start.
        ey = outer(64'sd1, eo);
        run_tile(fill(1), ey, eo, 1'b0);

        // Start pulses while busy are ignored.
        run_tile(imp_m(0, 0, 1), imp_y(0, 0, 1), 1'b0, 1'b1);

        // Reset mid-operation: abort, no done pulse, outputs cleared.
        @(negedge clk);
        m     = fill(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_y", 64'(|y), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        repeat (14) @(negedge clk);

        run_tile(imp_m(5, 5, 1), imp_y(5, 5, 1), 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("pending_expectations", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
